// File: rtl/dct_mac_pkg.sv
// Shared types and default sizing for the fdct MAC sequencer.
package dct_mac_pkg;

    localparam int unsigned TAPS_DEF     = 8;
    localparam int unsigned MULT_LAT_DEF = 2;
    localparam int unsigned IDX_W_DEF    = 3;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        HOLD
    } state_e;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tap_tag_t;

endpackage

// File: rtl/dct_mac_tap_delay.sv
// Tap tag shift register, time-aligned to the multiplier pipeline depth.
module dct_mac_tap_delay
    import dct_mac_pkg::*;
#(
    parameter int unsigned DEPTH = MULT_LAT_DEF
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     ena_i,
    input  tap_tag_t tag_i,
    output tap_tag_t tag_o
);

    tap_tag_t stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (ena_i) begin
            stage_q[0] <= tag_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dct_mac_sequencer.sv
// Sequences one fdct MAC unit: tap issue, accumulator strobes and result handshake.
module dct_mac_sequencer
    import dct_mac_pkg::*;
#(
    parameter int unsigned TAPS     = TAPS_DEF,
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned IDX_W    = IDX_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ena_i,
    input  logic             start_i,
    output logic             busy_o,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    output logic [IDX_W-1:0] coef_idx_o,
    output logic             acc_ld_o,
    output logic             acc_en_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             issue;
    logic             last_tap;
    tap_tag_t         tag_in;
    tap_tag_t         tag_out;

    assign issue    = ena_i && (state_q == FEED) && din_valid_i;
    assign last_tap = (cnt_q == LAST_IDX);

    always_comb begin
        tag_in       = '0;
        tag_in.valid = issue;
        tag_in.first = issue && (cnt_q == '0);
        tag_in.last  = issue && last_tap;
    end

    dct_mac_tap_delay #(
        .DEPTH (MULT_LAT)
    ) u_tap_delay (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ena_i  (ena_i),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    // Next-state and tap counter; everything freezes while ena_i is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ena_i) begin
            if (issue) begin
                cnt_d = last_tap ? '0 : cnt_q + IDX_W'(1);
            end
            case (state_q)
                IDLE:    if (start_i) state_d = FEED;
                FEED:    if (issue && last_tap) state_d = DRAIN;
                DRAIN:   if (tag_out.valid && tag_out.last) state_d = HOLD;
                HOLD:    if (out_ready_i) state_d = start_i ? FEED : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes are gated by ena_i so a frozen pipeline never touches the accumulator.
    assign busy_o      = (state_q != IDLE);
    assign din_ready_o = ena_i && (state_q == FEED);
    assign coef_idx_o  = cnt_q;
    assign acc_en_o    = ena_i && tag_out.valid;
    assign acc_ld_o    = ena_i && tag_out.valid && tag_out.first;
    assign out_valid_o = (state_q == HOLD);

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Bench for dct_mac_sequencer: directed vector table, corner sequences, random run vs. timing model.
module tb_dct_mac_sequencer;

    localparam int T = 8;
    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst_n, ena, start, din_valid, out_ready;
    logic       busy, din_ready, acc_ld, acc_en, out_valid;
    logic [2:0] coef_idx;

    int n_cmp = 0;
    int n_bad = 0;

    dct_mac_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ena_i       (ena),
        .start_i     (start),
        .busy_o      (busy),
        .din_valid_i (din_valid),
        .din_ready_o (din_ready),
        .coef_idx_o  (coef_idx),
        .acc_ld_o    (acc_ld),
        .acc_en_o    (acc_en),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    // Timing model: taps are stamped with the enabled-cycle time at which they reach the accumulator.
    typedef struct { int due; bit first; } due_t;
    due_t q[$];
    int   et = 0;
    int   m_taps = 0;
    int   m_done_at = 0;
    bit   m_active = 0;
    bit   m_hold = 0;

    logic       s_busy, s_rdy, s_ld, s_en, s_ov;
    logic [2:0] s_idx;

    function automatic void chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, want);
        end
    endfunction

    function automatic void model_check();
        int  e_busy, e_rdy, e_idx, e_ld, e_en, e_ov;
        if (!rst_n) begin
            e_busy = 0; e_rdy = 0; e_idx = 0; e_ld = 0; e_en = 0; e_ov = 0;
        end else begin
            e_busy = int'(m_active);
            e_ov   = int'(m_hold);
            e_rdy  = int'(ena && m_active && !m_hold && m_taps < T);
            e_idx  = m_taps % T;
            e_en   = int'(ena && q.size() > 0 && q[0].due == et);
            e_ld   = int'(e_en != 0 && q[0].first);
        end
        chk("busy", int'(busy), e_busy);
        chk("din_ready", int'(din_ready), e_rdy);
        chk("coef_idx", int'(coef_idx), e_idx);
        chk("acc_ld", int'(acc_ld), e_ld);
        chk("acc_en", int'(acc_en), e_en);
        chk("out_valid", int'(out_valid), e_ov);
    endfunction

    function automatic void model_update();
        if (!rst_n) begin
            q.delete();
            m_taps = 0; m_active = 0; m_hold = 0;
            return;
        end
        if (!ena) return;
        if (m_active && !m_hold && m_taps < T && din_valid) begin
            q.push_back('{due: et + L, first: (m_taps == 0)});
            if (m_taps == T - 1) m_done_at = et + L + 1;
            m_taps++;
        end
        if (q.size() > 0 && q[0].due == et) void'(q.pop_front());
        if (m_hold) begin
            if (out_ready) begin
                m_hold   = 0;
                m_active = start;
                if (start) m_taps = 0;
            end
        end else if (!m_active && start) begin
            m_active = 1;
            m_taps   = 0;
        end
        et++;
        if (m_active && !m_hold && m_taps == T && et == m_done_at) m_hold = 1;
    endfunction

    task automatic tick(input bit use_tbl, input logic [7:0] tbl_exp);
        @(negedge clk);
        s_busy = busy; s_rdy = din_ready; s_idx = coef_idx;
        s_ld = acc_ld; s_en = acc_en; s_ov = out_valid;
        model_check();
        if (use_tbl)
            chk("tbl_vec", int'({busy, din_ready, coef_idx, acc_ld, acc_en, out_valid}), int'(tbl_exp));
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct { logic [3:0] in; logic [7:0] want; } vec_t;
    vec_t tbl[15];

    initial begin
        int en_cnt, ov_first, ld_at, eps, bad_cnt;
        bit prev_ov;
        int idx_list[$];

        // inputs {ena,start,din_valid,out_ready}; outputs {busy,rdy,idx[2:0],ld,en,ov}
        tbl[0]  = '{4'b1110, 8'b0_0_000_0_0_0};
        tbl[1]  = '{4'b1010, 8'b1_1_000_0_0_0};
        tbl[2]  = '{4'b1010, 8'b1_1_001_0_0_0};
        tbl[3]  = '{4'b1010, 8'b1_1_010_1_1_0};
        tbl[4]  = '{4'b1010, 8'b1_1_011_0_1_0};
        tbl[5]  = '{4'b1010, 8'b1_1_100_0_1_0};
        tbl[6]  = '{4'b1010, 8'b1_1_101_0_1_0};
        tbl[7]  = '{4'b1010, 8'b1_1_110_0_1_0};
        tbl[8]  = '{4'b1010, 8'b1_1_111_0_1_0};
        tbl[9]  = '{4'b1010, 8'b1_0_000_0_1_0};
        tbl[10] = '{4'b1010, 8'b1_0_000_0_1_0};
        tbl[11] = '{4'b1010, 8'b1_0_000_0_0_1};
        tbl[12] = '{4'b1010, 8'b1_0_000_0_0_1};
        tbl[13] = '{4'b1011, 8'b1_0_000_0_0_1};
        tbl[14] = '{4'b1010, 8'b0_0_000_0_0_0};

        rst_n = 0; ena = 1; start = 0; din_valid = 0; out_ready = 0;
        #1;
        for (int c = 0; c < 3; c++) tick(0, 8'h0);
        rst_n = 1;
        tick(0, 8'h0);

        // Back-to-back row from the vector table
        for (int i = 0; i < 15; i++) begin
            {ena, start, din_valid, out_ready} = tbl[i].in;
            tick(1, tbl[i].want);
        end

        // Bubbles on taps 2 and 5
        en_cnt = 0; ov_first = -1;
        for (int c = 0; c < 16; c++) begin
            ena = 1; start = (c == 0); out_ready = 0;
            din_valid = !(c == 3 || c == 7);
            tick(0, 8'h0);
            if (s_en) en_cnt++;
            if (s_ov && ov_first < 0) ov_first = c;
            if (s_rdy && din_valid) idx_list.push_back(int'(s_idx));
        end
        chk("bub_en_count", en_cnt, 8);
        chk("bub_ov_cycle", ov_first, 13);
        chk("bub_idx_n", idx_list.size(), 8);
        foreach (idx_list[i]) chk("bub_idx_order", idx_list[i], i);

        // Backpressure in HOLD, then handshake chained with a new start
        start = 0; din_valid = 1; out_ready = 0;
        for (int c = 0; c < 4; c++) begin
            tick(0, 8'h0);
            chk("bp_ov", int'(s_ov), 1);
            chk("bp_en", int'(s_en), 0);
        end
        out_ready = 1; start = 1;
        tick(0, 8'h0);
        out_ready = 0; start = 0;
        tick(0, 8'h0);
        chk("chain_idx", int'(s_idx), 0);
        chk("chain_rdy", int'(s_rdy), 1);
        ld_at = -1;
        out_ready = 1;
        for (int rel = 2; rel < 15; rel++) begin
            tick(0, 8'h0);
            if (s_ld && ld_at < 0) ld_at = rel;
        end
        chk("chain_ld_cycle", ld_at, 1 + L);

        // Clock-enable freeze for 3 cycles in DRAIN
        ov_first = -1; bad_cnt = 0;
        for (int c = 0; c < 17; c++) begin
            ena = !(c >= 9 && c <= 11); start = (c == 0);
            din_valid = 1; out_ready = (c == 16);
            tick(0, 8'h0);
            if (!ena && (s_en || s_ld || s_rdy || !s_busy)) bad_cnt++;
            if (s_ov && ov_first < 0) ov_first = c;
        end
        chk("frz_hold", bad_cnt, 0);
        chk("frz_ov_cycle", ov_first, 14);

        // Start pulses during FEED and DRAIN are ignored
        ena = 1; out_ready = 1; din_valid = 1;
        eps = 0; prev_ov = 0; ov_first = -1;
        for (int c = 0; c < 25; c++) begin
            start = (c == 0 || c == 4 || c == 9);
            tick(0, 8'h0);
            if (s_ov && !prev_ov) eps++;
            if (s_ov && ov_first < 0) ov_first = c;
            prev_ov = s_ov;
        end
        chk("ign_episodes", eps, 1);
        chk("ign_ov_cycle", ov_first, 11);

        // Reset asserted while tap 4 is being issued
        out_ready = 0;
        for (int c = 0; c < 5; c++) begin
            start = (c == 0);
            tick(0, 8'h0);
        end
        start = 0;
        chk("rst_pre_idx", int'(coef_idx), 4);
        rst_n = 0;
        tick(0, 8'h0);
        tick(0, 8'h0);
        rst_n = 1;
        bad_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick(0, 8'h0);
            if (s_en || s_ld || s_busy || s_ov) bad_cnt++;
        end
        chk("rst_no_activity", bad_cnt, 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 499) != 0);
            ena       = ($urandom_range(0, 9) != 0);
            start     = ($urandom_range(0, 3) == 0);
            din_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            tick(0, 8'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dct_mac_sequencer.md
Name: dct_mac_sequencer

Overview:
- Sequences one DCT MAC unit (multiplier → mult_res register → accumulator) in the fdct datapath of the JPEG encoder.
- Accepts a start command and a stream of TAPS samples.
- Drives the coefficient index, then the accumulator load/enable strobes, time-aligned to the multiplier pipeline.
- Presents a valid/ready result strobe to the downstream zig-zag/quantiser stage.

Parameters:
- TAPS, 8: samples accumulated per DCT coefficient.
- MULT_LAT, 2: cycles from tap issue to mult_res valid (input register + mult_res register); range 1..4.
- IDX_W, 3: width of coef_idx; must satisfy 2**IDX_W >= TAPS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  global clock enable. When low, all state holds and all strobes are forced to 0.
- start  in  1  request one TAPS-sample accumulation.
- busy  out  1  high in every state except IDLE.
- din_valid  in  1  upstream sample available.
- din_ready  out  1  sequencer takes a tap this cycle.
- coef_idx  out  IDX_W  coefficient ROM / sample-mux index for the issued tap.
- acc_ld  out  1  accumulator loads mult_res (first tap).
- acc_en  out  1  accumulator adds mult_res (every tap, including the first).
- out_valid  out  1  accumulator holds a complete result.
- out_ready  in  1  downstream has taken the result.

Behaviour:
- Reset (rst=0, async): state=IDLE; tap counter=0; delay line cleared. Outputs: busy=0, din_ready=0, coef_idx=0, acc_ld=0, acc_en=0, out_valid=0. Reset mid-operation discards the partial result; no strobe may follow reset release.
- Tap handshake: a tap is issued when din_valid & din_ready. coef_idx equals the current tap count (0..TAPS-1) and is valid in the issue cycle.
- State machine (all transitions qualified by ena=1):
  - IDLE: start → FEED.
  - FEED: din_ready=1. On the tap with count TAPS-1 → DRAIN. Cycles with din_valid=0 are bubbles; the counter holds.
  - DRAIN: din_ready=0. Waits until the last tap leaves the delay line, then → HOLD on the following cycle.
  - HOLD: out_valid=1. On out_ready=1: → FEED if start=1 in the same cycle, else → IDLE. With out_ready=0, stays in HOLD and out_valid stays 1.
- start outside IDLE and outside the HOLD handshake cycle is ignored; it is not queued.
- Delay line: MULT_LAT stages carrying {valid, first, last}. At the stage output:
  - acc_en = valid.
  - acc_ld = valid & first.
  - Bubbles propagate as valid=0.
- Latency, back-to-back input, L=MULT_LAT:
  - start at cycle 0; taps issued at cycles 1..TAPS.
  - acc_ld at cycle 1+L; acc_en at cycles 1+L..TAPS+L.
  - out_valid from cycle TAPS+L+1. Defaults give cycle 11.
- Tap counter wraps to 0 after TAPS-1; coef_idx never exceeds TAPS-1.
- ena=0 in any state: registers, delay line and counter freeze; acc_ld, acc_en and din_ready are 0.
  - out_valid holds its value. A handshake completes only when ena=1.
  - On ena returning to 1, the sequence resumes exactly where it stopped.
- Only one accumulation is in flight. The accumulator is never overwritten while out_valid=1.

Decomposition:
- Package dct_mac_pkg:
  - state enum {IDLE, FEED, DRAIN, HOLD}.
  - localparams for TAPS/MULT_LAT defaults.
  - tap_tag_t struct {valid, first, last}.
- Sub-module dct_mac_tap_delay: parameterised MULT_LAT-deep tap_tag_t shift register with ena and async active-low rst.
- FSM, tap counter and output logic stay in dct_mac_sequencer.

Test Plan:
- Reset then idle: rst low for 3 cycles, start=0 → every output 0 and busy=0; asserting rst mid-FEED (tap 4) clears state with no acc_* strobes after release.
- Back-to-back row: start at cycle 0, din_valid held 1 → coef_idx 0..7 on cycles 1..8; acc_ld only at cycle 3; acc_en cycles 3..10; out_valid rises at cycle 11.
- Bubbles: din_valid low on taps 2 and 5 (one cycle each) → coef_idx still 0..7 in order; acc_en shows matching gaps; acc_en count = 8; out_valid at cycle 13.
- Backpressure and chaining: out_ready low for 4 cycles in HOLD → out_valid stays 1 and no acc_en. Then out_ready=1 together with start=1 → next cycle FEED with coef_idx=0 and a new acc_ld L cycles later.
- Clock-enable freeze: ena low for 3 cycles during DRAIN → strobes 0 and state held; after resume, out_valid arrives exactly 3 cycles later than the nominal cycle 11.
- Ignored start: start pulsed during FEED and DRAIN → no effect; exactly one out_valid episode per accepted start.
